// File: rtl/fetch_unit.sv
// hc816 instruction fetch stage: owns the program counter, paces ROM reads by ROM_WAIT
// wait states, and presents each fetched word to the decoder over a valid/ready handshake.
module fetch_unit #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    INST_WIDTH   = 16,
    parameter int unsigned           ROM_WAIT     = 0,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_Address,
    input  logic [INST_WIDTH-1:0] rom_Data,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    input  logic                  halt
);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_CAPT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_CNT = 4'(ROM_WAIT);

    state_t                  state;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   fpc;
    logic                    free;
    state_t                  entry_state;

    assign rom_Address = fpc;
    assign free        = !inst_valid || inst_ready;
    // Without wait states there is nothing to count, so every (re)start lands in S_CAPT.
    assign entry_state = (ROM_WAIT == 0) ? S_CAPT : S_WAIT;

    // NOTE: all state is assigned with <= so every branch below sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= entry_state;
            cnt        <= '0;
            fpc        <= RESET_VECTOR;
            inst_out   <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else if (jump_en) begin
            // Flush wins over everything, including a transfer the decoder is taking.
            fpc        <= jump_target;
            cnt        <= '0;
            inst_valid <= 1'b0;
            state      <= halt ? S_HALT : entry_state;
        end else begin
            if (inst_valid && inst_ready) begin
                inst_valid <= 1'b0;
            end
            if (halt) begin
                state <= S_HALT;
                cnt   <= '0;
            end else begin
                case (state)
                    S_HALT: begin
                        cnt   <= '0;
                        state <= entry_state;
                    end
                    S_WAIT: begin
                        cnt <= cnt + 4'd1;
                        if (4'(cnt + 4'd1) == WAIT_CNT) begin
                            state <= S_CAPT;
                        end
                    end
                    S_CAPT: begin
                        // Not free means a word is parked and unread: hold fpc so ROM stays stable.
                        if (free) begin
                            inst_out   <= rom_Data;
                            inst_pc    <= fpc;
                            inst_valid <= 1'b1;
                            fpc        <= fpc + ADDR_WIDTH'(1);
                            cnt        <= '0;
                            state      <= entry_state;
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= entry_state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: four instances (ROM_WAIT 0..3) share one stimulus stream and are
// each compared every cycle against a counter-based model of the fetch rules.
module tb_fetch_unit;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_ready = 1'b1;
    logic        jump_en = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] jump_target = 16'h0000;

    logic [15:0] rom_addr   [N];
    logic [15:0] rom_data   [N];
    logic [15:0] inst_out   [N];
    logic [15:0] inst_pc    [N];
    logic        inst_valid [N];

    // Model state: address being fetched, wait cycles elapsed, halted flag, output buffer.
    logic [15:0] m_fpc    [N];
    int          m_cnt    [N];
    bit          m_halted [N];
    bit          m_valid  [N];
    logic [15:0] m_out    [N];
    logic [15:0] m_pc     [N];

    int total = 0;
    int bad   = 0;
    int halt_len = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : gen_dut
        assign rom_data[g] = rom_word(rom_addr[g]);

        fetch_unit #(.ROM_WAIT(g)) dut (
            .clk         (clk),
            .reset       (reset),
            .rom_Address (rom_addr[g]),
            .rom_Data    (rom_data[g]),
            .inst_out    (inst_out[g]),
            .inst_pc     (inst_pc[g]),
            .inst_valid  (inst_valid[g]),
            .inst_ready  (inst_ready),
            .jump_en     (jump_en),
            .jump_target (jump_target),
            .halt        (halt)
        );

        always @(posedge clk or posedge reset) begin
            if (reset) begin
                m_fpc[g]    = 16'h0000;
                m_cnt[g]    = 0;
                m_halted[g] = 1'b0;
                m_valid[g]  = 1'b0;
                m_out[g]    = 16'h0000;
                m_pc[g]     = 16'h0000;
            end else if (jump_en) begin
                m_fpc[g]    = jump_target;
                m_cnt[g]    = 0;
                m_valid[g]  = 1'b0;
                m_halted[g] = halt;
            end else if (halt || m_halted[g] || m_cnt[g] < g) begin
                // No capture: a held word still leaves if the decoder takes it.
                if (m_valid[g] && inst_ready) m_valid[g] = 1'b0;
                if (halt) begin
                    m_halted[g] = 1'b1;
                    m_cnt[g]    = 0;
                end else if (m_halted[g]) begin
                    m_halted[g] = 1'b0;
                    m_cnt[g]    = 0;
                end else begin
                    m_cnt[g]++;
                end
            end else if (!m_valid[g] || inst_ready) begin
                m_out[g]   = rom_word(m_fpc[g]);
                m_pc[g]    = m_fpc[g];
                m_valid[g] = 1'b1;
                m_fpc[g]   = m_fpc[g] + 16'h0001;
                m_cnt[g]   = 0;
            end
        end

        always @(negedge clk) begin
            check($sformatf("w%0d_rom_addr", g), 32'(rom_addr[g]), 32'(m_fpc[g]));
            check($sformatf("w%0d_valid", g), 32'(inst_valid[g]), 32'(m_valid[g]));
            if (m_valid[g]) begin
                check($sformatf("w%0d_inst_pc", g), 32'(inst_pc[g]), 32'(m_pc[g]));
                check($sformatf("w%0d_inst_out", g), 32'(inst_out[g]), 32'(m_out[g]));
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_valid%0d", i), 32'(inst_valid[i]), 32'd0);
            check($sformatf("rst_out%0d", i), 32'(inst_out[i]), 32'h0000);
            check($sformatf("rst_addr%0d", i), 32'(rom_addr[i]), 32'h0000);
        end
        #1 reset = 1'b0;

        // One word per cycle at ROM_WAIT=0; first word at edge 3 for ROM_WAIT=2.
        @(negedge clk);
        check("w0_first_valid", 32'(inst_valid[0]), 32'd1);
        check("w0_first_pc", 32'(inst_pc[0]), 32'h0000);
        check("w0_first_out", 32'(inst_out[0]), 32'h1000);
        check("w2_not_yet", 32'(inst_valid[2]), 32'd0);
        @(negedge clk);
        check("w0_second_out", 32'(inst_out[0]), 32'h1001);
        check("w2_addr_stable", 32'(rom_addr[2]), 32'h0000);
        @(negedge clk);
        check("w0_third_pc", 32'(inst_pc[0]), 32'h0002);
        check("w2_first_valid", 32'(inst_valid[2]), 32'd1);
        check("w2_first_out", 32'(inst_out[2]), 32'h1000);
        check("w2_next_addr", 32'(rom_addr[2]), 32'h0001);

        // Jump flushes the buffer, then fetch runs across the address wrap.
        #1 jump_en = 1'b1;
        jump_target = 16'hFFFF;
        @(negedge clk);
        check("jump_flush", 32'(inst_valid[0]), 32'd0);
        check("jump_addr", 32'(rom_addr[0]), 32'h0000FFFF);
        #1 jump_en = 1'b0;
        @(negedge clk);
        check("wrap_pc_ffff", 32'(inst_pc[0]), 32'h0000FFFF);
        check("wrap_out", 32'(inst_out[0]), 32'h00000FFF);
        @(negedge clk);
        check("wrap_pc_0000", 32'(inst_pc[0]), 32'h0000);
        check("wrap_out_1000", 32'(inst_out[0]), 32'h1000);

        // ROM_WAIT=3 instance is two counts into its wait: reset must act immediately.
        #1 reset = 1'b1;
        #1;
        check("async_rst_addr", 32'(rom_addr[3]), 32'h0000);
        check("async_rst_valid", 32'(inst_valid[3]), 32'd0);
        check("async_rst_addr_w0", 32'(rom_addr[0]), 32'h0000);
        @(negedge clk);
        #1 reset = 1'b0;
        inst_ready = 1'b0;

        // Decoder stalls: first word held, address held, then drains without a bubble.
        repeat (5) @(negedge clk);
        check("stall_out", 32'(inst_out[0]), 32'h1000);
        check("stall_addr", 32'(rom_addr[0]), 32'h0001);
        #1 inst_ready = 1'b1;
        @(negedge clk);
        check("drain_out1", 32'(inst_out[0]), 32'h1001);
        @(negedge clk);
        check("drain_out2", 32'(inst_out[0]), 32'h1002);
        check("drain_valid", 32'(inst_valid[0]), 32'd1);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            #1;
            reset       = ($urandom_range(0, 499) == 0);
            inst_ready  = ($urandom_range(0, 3) != 0);
            jump_en     = ($urandom_range(0, 29) == 0);
            jump_target = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            if (halt_len > 0) begin
                halt_len--;
                halt = 1'b1;
            end else if ($urandom_range(0, 39) == 0) begin
                halt_len = $urandom_range(0, 6);
                halt = 1'b1;
            end else begin
                halt = 1'b0;
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
